// File: rtl/sram_arbiter.sv
// Merges an instruction and a data sram-like requester onto one in-order sram-like slave.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN swaps fixed data-first priority for round-robin.
module sram_arbiter #(
  parameter int OT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(OT_DEPTH);
  localparam int CW = PW + 1;

  logic [OT_DEPTH-1:0] id_q;
  logic [PW-1:0]       wptr_q;
  logic [PW-1:0]       rptr_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       count_d;
  logic                lock_q;
  logic                lock_sel_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic                last_q;
`endif

  logic full_s;
  logic sel_data_s;
  logic push_s;
  logic pop_s;
  logic head_s;

  assign full_s  = (count_q == CW'(OT_DEPTH));
  assign mem_req = resetn & (inst_req | data_req) & ~full_s;
  assign push_s  = mem_req & mem_addr_ok;
  assign pop_s   = mem_data_ok & (count_q != CW'(0));
  assign head_s  = id_q[rptr_q];

  // Source select: a pending unaccepted request keeps its grant until the slave takes it.
  always_comb begin
    sel_data_s = 1'b0;
    if (lock_q) begin
      sel_data_s = lock_sel_q;
    end else begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      if (inst_req & data_req) begin
        sel_data_s = ~last_q;
      end else begin
        sel_data_s = data_req;
      end
`else
      sel_data_s = data_req;
`endif
    end
  end

  // Request field mux from the granted source.
  always_comb begin
    if (sel_data_s) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  assign inst_addr_ok = push_s & ~sel_data_s;
  assign data_addr_ok = push_s &  sel_data_s;
  // count_q is held at zero during reset, so pop_s already gates the data_ok outputs.
  assign inst_data_ok = pop_s & ~head_s;
  assign data_data_ok = pop_s &  head_s;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Outstanding counter next state.
  always_comb begin
    count_d = count_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Ordering FIFO, pointers, grant lock and last-grant state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      count_q <= count_d;
      if (push_s) begin
        id_q[wptr_q] <= sel_data_s;
        wptr_q       <= wptr_q + PW'(1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_q       <= sel_data_s;
`endif
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PW'(1);
      end
      if (mem_req && !mem_addr_ok) begin
        lock_q     <= 1'b1;
        lock_sel_q <= sel_data_s;
      end else if (push_s) begin
        lock_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized plus directed bench for sram_arbiter: rule-level model checks arbitration each cycle,
// a scoreboard queue of accepted source IDs is checked by a separate data_ok monitor.
module tb_sram_arbiter;

  localparam int OT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = '0;
  logic [3:0]  inst_wstrb = '0;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = '0;
  logic [3:0]  data_wstrb = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = '0;

  sram_arbiter #(.OT_DEPTH(OT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model state: outstanding count, lock, last grant, accepted-ID scoreboard.
  int  m_count = 0;
  bit  m_locked = 1'b0;
  bit  m_lsel = 1'b0;
  bit  m_last = 1'b1;
  bit  exp_q[$];
  bit  m_full, m_req, m_sel, m_push, m_pop;
  logic [38:0] m_fields;

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'(0));
      chk("rst_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
      m_count  = 0;
      m_locked = 1'b0;
      m_lsel   = 1'b0;
      m_last   = 1'b1;
      exp_q.delete();
    end else begin
      m_full = (m_count == OT);
      m_req  = (inst_req || data_req) && !m_full;
      if (m_locked) m_sel = m_lsel;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      else if (inst_req && data_req) m_sel = !m_last;
`endif
      else m_sel = data_req;
      chk("mem_req", 64'(mem_req), 64'(m_req));
      if (m_req) begin
        m_fields = m_sel ? {data_wr, data_size, data_wstrb, data_wdata}
                         : {inst_wr, inst_size, inst_wstrb, inst_wdata};
        chk("mem_addr", 64'(mem_addr), 64'(m_sel ? data_addr : inst_addr));
        chk("mem_fields", 64'({mem_wr, mem_size, mem_wstrb, mem_wdata}), 64'(m_fields));
      end
      m_push = m_req && mem_addr_ok;
      m_pop  = mem_data_ok && (m_count > 0);
      chk("addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'({m_push && !m_sel, m_push && m_sel}));
      chk("data_ok_any", 64'(inst_data_ok | data_data_ok), 64'(m_pop));
      chk("rdata", 64'({inst_rdata, data_rdata}), 64'({mem_rdata, mem_rdata}));
      if (m_push) begin
        exp_q.push_back(m_sel);
        m_count++;
        m_last = m_sel;
        m_locked = 1'b0;
      end else if (m_req) begin
        m_locked = 1'b1;
        m_lsel   = m_sel;
      end
      if (m_pop) m_count--;
    end
  end

  // Monitor: every data_ok the DUT presents must match the oldest accepted source.
  bit got_id;
  always @(negedge clk) begin
    if (resetn && (inst_data_ok || data_data_ok)) begin
      got_id = data_data_ok;
      if (inst_data_ok && data_data_ok) begin
        chk("data_ok_both", 64'({inst_data_ok, data_data_ok}), 64'(0));
      end else if (exp_q.size() == 0) begin
        chk("data_ok_underflow", 64'(1), 64'(0));
      end else begin
        chk("data_ok_src", 64'(got_id), 64'(exp_q.pop_front()));
      end
    end
  end

  bit i_hs = 1'b0, d_hs = 1'b0;
  always @(negedge clk) begin
    i_hs = inst_addr_ok;
    d_hs = data_addr_ok;
  end

  task automatic set(input bit ir, input bit dr, input bit aok, input bit dok);
    if (!inst_req || i_hs) begin
      inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_wstrb = 4'($urandom);
      inst_addr = $urandom; inst_wdata = $urandom;
    end
    if (!data_req || d_hs) begin
      data_wr = 1'($urandom); data_size = 2'($urandom); data_wstrb = 4'($urandom);
      data_addr = $urandom; data_wdata = $urandom;
    end
    inst_req = ir; data_req = dr; mem_addr_ok = aok; mem_data_ok = dok;
    mem_rdata = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit ir, input bit dr, input bit aok, input bit dok);
    set(ir, dr, aok, dok);
    tick();
  endtask

  logic [1:0] order [4];
  bit ir, dr;

  initial begin
    order[0] = 2'b10; order[1] = 2'b01; order[2] = 2'b01; order[3] = 2'b10;
    resetn = 1'b0;
    step(1, 1, 1, 1);
    step(1, 1, 1, 1);
    resetn = 1'b1;
    set(0, 0, 0, 0); #1;
    chk("post_rst_mem_req", 64'(mem_req), 64'(0));
    tick();

`ifndef SRAM_ARB_ROUND_ROBIN_EN
    set(1, 1, 1, 0); #1;
    chk("prio_data_aok", 64'({inst_addr_ok, data_addr_ok}), 64'(2'b01));
    chk("prio_addr", 64'(mem_addr), 64'(data_addr));
    tick();
    step(0, 0, 0, 1);
`endif

    // Lock: inst waits three cycles while data joins, inst must stay granted.
    step(1, 0, 0, 0);
    set(1, 1, 0, 0); #1;
    chk("lock_addr", 64'(mem_addr), 64'(inst_addr));
    tick();
    step(1, 1, 0, 0);
    set(1, 1, 1, 0); #1;
    chk("lock_grant", 64'({inst_addr_ok, data_addr_ok}), 64'(2'b10));
    tick();
    set(0, 1, 1, 0); #1;
    chk("after_lock_grant", 64'(data_addr_ok), 64'(1));
    tick();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Fill to OT_DEPTH, confirm blocking, then drain in order.
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    set(1, 1, 1, 0); #1;
    chk("full_mem_req", 64'(mem_req), 64'(0));
    chk("full_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'(0));
    tick();
    for (int k = 0; k < 4; k++) begin
      set(0, 0, 0, 1); #1;
      chk("drain_order", 64'({inst_data_ok, data_data_ok}), 64'(order[k]));
      tick();
    end

    // Push and pop in the same cycle at count 2.
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    set(1, 0, 1, 1); #1;
    chk("pushpop_route", 64'({inst_data_ok, data_data_ok}), 64'(2'b10));
    tick();
    set(0, 0, 0, 1); #1;
    chk("pushpop_next", 64'({inst_data_ok, data_data_ok}), 64'(2'b01));
    tick();
    step(0, 0, 0, 1);

    // Spurious data_ok when empty, then reset with three in flight.
    set(0, 0, 0, 1); #1;
    chk("empty_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
    tick();
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    resetn = 1'b0;
    set(1, 1, 1, 0); #1;
    chk("rst_mid_mem_req", 64'(mem_req), 64'(0));
    tick();
    resetn = 1'b1;
    set(1, 0, 0, 1); #1;
    chk("stale_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
    chk("rst_count_clear", 64'(mem_req), 64'(1));
    tick();
    step(1, 0, 1, 0);
    step(0, 0, 0, 1);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    resetn = 1'b0;
    step(0, 0, 0, 0);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set(1, 1, 1, 1); #1;
      chk("rr_grant", 64'({inst_addr_ok, data_addr_ok}), 64'((k % 2 == 0) ? 2'b10 : 2'b01));
      tick();
    end
`endif

    // Randomized traffic with requests held until accepted.
    for (int c = 0; c < 3000; c++) begin
      ir = (inst_req && !i_hs) ? 1'b1 : 1'($urandom_range(0, 1));
      dr = (data_req && !d_hs) ? 1'b1 : 1'($urandom_range(0, 1));
      step(ir, dr, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) begin
        resetn = 1'b0;
        step(0, 0, 0, 0);
        resetn = 1'b1;
      end
    end
    for (int c = 0; c < 20; c++) step(0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter OT_DEPTH, default 4: maximum outstanding (address-accepted, data-not-returned) transactions; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports inst_req/inst_wr, input, 1/1: instruction-side request and write flag.
REQ-005 SHALL have ports inst_size/inst_wstrb/inst_addr/inst_wdata, input, 2/4/32/32: instruction-side request fields.
REQ-006 SHALL have ports inst_addr_ok/inst_data_ok, output, 1/1: instruction-side handshakes; inst_rdata, output, 32: read data.
REQ-007 SHALL have ports data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata, input, 1/1/2/4/32/32: data-side request.
REQ-008 SHALL have ports data_addr_ok/data_data_ok, output, 1/1; data_rdata, output, 32: data-side handshakes and read data.
REQ-009 SHALL have ports mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata, output, 1/1/2/4/32/32: shared sram-like master request.
REQ-010 SHALL have ports mem_addr_ok/mem_data_ok, input, 1/1; mem_rdata, input, 32: shared slave responses.

Function
REQ-011 SHALL merge two sram-like requesters onto one sram-like port; slave returns data_ok strictly in request order.
REQ-012 SHALL drive mem_req = (inst_req | data_req) & ~full, combinationally, zero added latency.
REQ-013 SHALL select by fixed priority data over inst when no grant is locked; mem_wr/size/wstrb/addr/wdata muxed from selected source.
REQ-014 SHALL lock the selection when mem_req=1 & mem_addr_ok=0; held until mem_addr_ok=1, even if the other source requests (no switching mid-request).
REQ-015 SHALL assert <src>_addr_ok = selected & mem_req & mem_addr_ok; the unselected source sees addr_ok=0.
REQ-016 SHALL keep an OT_DEPTH-entry FIFO of source IDs (0=inst, 1=data) plus count of width log2(OT_DEPTH)+1.
REQ-017 SHALL push selected ID on mem_req & mem_addr_ok; pop head on mem_data_ok & count!=0; simultaneous push+pop leaves count unchanged, both pointers advance.
REQ-018 SHALL wrap read/write pointers modulo OT_DEPTH.
REQ-019 SHALL define full = (count == OT_DEPTH); when full, mem_req=0 and both addr_ok=0; a pop in the same cycle does not unblock until next cycle.
REQ-020 SHALL route mem_data_ok to inst_data_ok or data_data_ok per FIFO head, same cycle; the other data_ok=0.
REQ-021 SHALL ignore mem_data_ok when count==0: no data_ok output, no state change.
REQ-022 SHALL drive inst_rdata = data_rdata = mem_rdata unconditionally; validity qualified only by data_ok.

Reset
REQ-023 SHALL on resetn=0 immediately clear count, pointers, lock and round-robin pointer; mem_req, all addr_ok and data_ok outputs read 0 while resetn=0.
REQ-024 SHALL discard in-flight transactions on reset mid-operation; later mem_data_ok for them is ignored per REQ-021.

Configuration
REQ-025 SHALL, with macro SRAM_ARB_ROUND_ROBIN_EN defined, replace REQ-013 priority with round-robin: when both request unlocked, grant the source not granted last; last-grant register (reset = data, so inst wins first tie) updates on each accepted handshake.
REQ-026 SHALL, without SRAM_ARB_ROUND_ROBIN_EN, use fixed data-over-inst priority and contain no last-grant register.

Verification
REQ-027 SHALL cover: inst_req=1, data_req=1, mem_addr_ok=1 same cycle (fixed priority) -> data_addr_ok=1, inst_addr_ok=0, mem_addr=data_addr.
REQ-028 SHALL cover: inst_req=1 alone, mem_addr_ok=0 for 3 cycles, data_req rises cycle 2 -> mem_addr stays inst_addr until addr_ok, then data granted.
REQ-029 SHALL cover: 4 accepted requests (inst,data,data,inst), no data_ok -> count=4, mem_req=0; then 4 mem_data_ok -> data_ok order inst,data,data,inst.
REQ-030 SHALL cover: count=2 with push and mem_data_ok same cycle -> count stays 2, head data_ok routed correctly.
REQ-031 SHALL cover: mem_data_ok with count=0 -> both data_ok=0; resetn low mid-stream with count=3 -> count=0, mem_req=0.
REQ-032 SHALL cover (SRAM_ARB_ROUND_ROBIN_EN): both requesting continuously, addr_ok=1 -> grants alternate inst,data,inst,data.
